// File: rtl/bcd_display_pkg.sv
// rtl/bcd_display_pkg.sv - seven-segment pattern constants and BCD decode function
package bcd_display_pkg;

    // Active-high segment patterns, bit0=a ... bit6=g
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;

    // Codes 10..15 are not BCD and render as a dash
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        case (bcd)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_DASH;
        endcase
    endfunction

endpackage

// File: rtl/bcd_display_mux_if.sv
// rtl/bcd_display_mux_if.sv - digit inputs and display pin outputs of the scan driver
interface bcd_display_mux_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp_mask;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   digit_sel;
    logic                    frame_tick;

    modport master (
        output digits, dp_mask,
        input  seg, dp, digit_sel, frame_tick
    );

    modport slave (
        input  digits, dp_mask,
        output seg, dp, digit_sel, frame_tick
    );
endinterface

// File: rtl/bcd_seg_decoder.sv
// rtl/bcd_seg_decoder.sv - combinational BCD to active-high seven-segment decoder
module bcd_seg_decoder
    import bcd_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    assign seg = bcd_to_seg(bcd);

endmodule

// File: rtl/bcd_display_mux.sv
// rtl/bcd_display_mux.sv - frame-coherent multiplexed seven-segment scanner (option: BCD_DISPLAY_LZB_EN)
module bcd_display_mux
    import bcd_display_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int GUARD_CLKS     = 1,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit SEL_ACTIVE_LOW = 1'b0
) (
    input  logic              sys_clk,
    input  logic              sys_reset,
    bcd_display_mux_if.slave  bus
);

    localparam int PRE_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [6:0]            SEG_INV = {7{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] SEL_INV = {NUM_DIGITS{SEL_ACTIVE_LOW}};

    logic [PRE_W-1:0]        pre;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] digits_snap;
    logic [NUM_DIGITS-1:0]   dp_snap;

    logic                    pre_last;
    logic                    idx_last;
    logic                    snap_now;
    logic                    guard;
    logic [4*NUM_DIGITS-1:0] digits_eff;
    logic [NUM_DIGITS-1:0]   dp_eff;
    logic [NUM_DIGITS-1:0]   blank_vec;

    logic [3:0]              cur_bcd;
    logic                    cur_dp;
    logic                    cur_blank;
    logic [NUM_DIGITS-1:0]   cur_onehot;
    logic [6:0]              cur_seg;

    logic [6:0]              seg_q;
    logic                    dp_q;
    logic [NUM_DIGITS-1:0]   sel_q;
    logic                    frame_tick_q;

    assign pre_last = (pre == PRE_W'(SCAN_DIV - 1));
    assign idx_last = (idx == IDX_W'(NUM_DIGITS - 1));
    assign snap_now = (pre == '0) && (idx == '0);
    assign guard    = (pre < PRE_W'(GUARD_CLKS));

    // On the snapshot clock the frame registers are still being loaded, so
    // the guard cycle of digit 0 looks straight at the inputs being captured.
    assign digits_eff = snap_now ? bus.digits  : digits_snap;
    assign dp_eff     = snap_now ? bus.dp_mask : dp_snap;

`ifdef BCD_DISPLAY_LZB_EN
    logic zero_run;

    // Blank a digit when it and everything above it is zero, unless its dp is requested
    always_comb begin
        zero_run  = 1'b1;
        blank_vec = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run     = zero_run & (digits_eff[4*i +: 4] == 4'd0);
            blank_vec[i] = zero_run & ~dp_eff[i];
        end
    end
`else
    assign blank_vec = '0;
`endif

    // Select the digit currently being scanned
    always_comb begin
        cur_bcd    = 4'd0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        cur_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_bcd       = digits_eff[4*i +: 4];
                cur_dp        = dp_eff[i];
                cur_blank     = blank_vec[i];
                cur_onehot[i] = 1'b1;
            end
        end
    end

    bcd_seg_decoder u_dec (
        .bcd (cur_bcd),
        .seg (cur_seg)
    );

    // Prescaler and digit index scan counters
    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            pre <= '0;
            idx <= '0;
        end else if (pre_last) begin
            pre <= '0;
            idx <= idx_last ? '0 : idx + 1'b1;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // Capture the whole frame at the start of digit 0's slot
    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            digits_snap <= '0;
            dp_snap     <= '0;
        end else if (snap_now) begin
            digits_snap <= bus.digits;
            dp_snap     <= bus.dp_mask;
        end
    end

    // Registered pin drivers with polarity applied last
    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            seg_q        <= SEG_INV;
            dp_q         <= SEG_ACTIVE_LOW;
            sel_q        <= SEL_INV;
            frame_tick_q <= 1'b0;
        end else begin
            seg_q        <= (cur_blank ? 7'h00 : cur_seg) ^ SEG_INV;
            dp_q         <= (cur_dp & ~cur_blank) ^ SEG_ACTIVE_LOW;
            sel_q        <= ((guard | cur_blank) ? '0 : cur_onehot) ^ SEL_INV;
            frame_tick_q <= snap_now;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.digit_sel  = sel_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: doc/bcd_display_mux.md
# bcd_display_mux

Time-multiplexed seven-segment driver that consumes the packed BCD `count` outputs of a chain of BCD counter digits and scans them onto a common-bus display. It sits downstream of the counter chain and upstream of the board's segment/anode pins. It snapshots all digits once per scan frame so a display never shows a torn value.

## Interface
- `NUM_DIGITS`, 4: number of BCD digits scanned, 1..8.
- `SCAN_DIV`, 1000: clocks per digit slot, ≥ 2.
- `GUARD_CLKS`, 1: clocks at the start of each slot with all enables off (anti-ghosting); 0 ≤ GUARD_CLKS < SCAN_DIV.
- `SEG_ACTIVE_LOW`, 0: 1 inverts `seg` and `dp` at the pins.
- `SEL_ACTIVE_LOW`, 0: 1 inverts `digit_sel`.
- `sys_clk` in 1: system clock.
- `sys_reset` in 1: asynchronous, active-high reset.
- `digits` in 4*NUM_DIGITS: packed BCD; `digits[3:0]` is the least significant digit.
- `dp_mask` in NUM_DIGITS: decimal point request per digit.
- `seg` out 7: segments, bit0=a … bit6=g.
- `dp` out 1: decimal point.
- `digit_sel` out NUM_DIGITS: one-hot digit enable; `digit_sel[0]` drives digit 0.
- `frame_tick` out 1: one-cycle pulse when a new snapshot is taken.

## Operation
- Prescaler `pre` counts 0..SCAN_DIV-1 and wraps. Digit index `idx` advances when `pre == SCAN_DIV-1` and wraps from NUM_DIGITS-1 to 0.
- Snapshot: when `pre == 0` and `idx == 0`, `digits`/`dp_mask` are latched into the frame registers and `frame_tick` pulses. This includes the first clock after reset release.
- Slot enable: when `pre < GUARD_CLKS`, all `digit_sel` are inactive. Otherwise only bit `idx` is active, unless that digit is blanked.
- Decode (active-high, gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Invalid codes 10..15 show 40 (a dash).
- `seg` and `dp` show the selected digit during the whole slot, including guard cycles. `dp = dp_mask_snap[idx]`.
- Polarity inversion is applied only at the output registers.
- Input `digits` changing mid-frame has no visible effect until the next snapshot.

## Timing
- All outputs are registered: one clock of latency from `pre`/`idx`/snapshot state.
- Reset values: `pre=0`, `idx=0`, snapshots = 0, `frame_tick=0`.
  - Outputs are inactive: `digit_sel` all off, `seg` and `dp` off, each at its configured polarity.
- After release, let edge E0 be the first rising edge. Snapshot is taken at E0. `frame_tick` is high in the cycle after E0.
  - `digit_sel[0]` first asserts after edge E0+GUARD_CLKS.
  - With the defaults (SCAN_DIV=1000, GUARD_CLKS=1), it stays asserted for SCAN_DIV-GUARD_CLKS clocks.
- Frame period = NUM_DIGITS*SCAN_DIV clocks. `frame_tick` period is identical.
- Reset asserted mid-slot: all outputs go inactive asynchronously; the scan restarts at digit 0 with a fresh snapshot.
- NUM_DIGITS=1: `idx` stays 0. The snapshot is taken every SCAN_DIV clocks.

## Configuration
- `BCD_DISPLAY_LZB_EN` defined: leading-zero blanking.
  - Digit i (i ≥ 1) is blanked when the snapshot digit i and every more significant digit equal 0. Blanked means `digit_sel` stays inactive for that slot and `seg` and `dp` are off.
  - Invalid codes count as nonzero.
  - Digit 0 is never blanked.
  - A set `dp_mask` bit prevents blanking of that digit.
- Undefined: every digit is displayed. The blanking logic is not compiled.

## Structure
- Package `bcd_display_pkg`:
  - segment pattern constants `SEG_0`..`SEG_9` and `SEG_DASH`;
  - function `bcd_to_seg(logic [3:0]) -> logic [6:0]`.
- Sub-module `bcd_seg_decoder`: combinational, one 4-bit BCD in, 7-bit active-high pattern out, wraps the package function. Instantiated once, after the digit mux.
- Top level holds the prescaler, index, snapshot, blanking and output registers.

## Test plan
All cases use NUM_DIGITS=4, SCAN_DIV=8, GUARD_CLKS=1 and active-high polarity, unless noted.

- Reset/first slot: hold reset 2 clocks, release with digits=16'h1234.
  - All outputs are 0 during reset. `frame_tick` pulses once.
  - `digit_sel=0001` with `seg=66` for 7 clocks, then 1 guard clock with `digit_sel=0000`.
  - Next slot: `digit_sel=0010` with `seg=4F`.
- Frame coherence: change digits to 16'h9876 midway through digit 1's slot.
  - Digits 2 and 3 still show 2 (`5B`) and 1 (`06`).
  - The next frame shows 6, 7, 8, 9 (`7D`, `07`, `7F`, `6F`).
  - `frame_tick` spacing is 32 clocks.
- Invalid code: digits=16'h00A5.
  - Digit 1 shows `40`; digit 0 shows `6D`.
- LZB (macro defined): digits=16'h0042, dp_mask=4'b0000.
  - Digits 3 and 2 slots have `digit_sel=0000` and `seg=00`.
  - Digit 1 shows `66`; digit 0 shows `5B`.
  - With dp_mask=4'b0100: digit 2 is shown as `3F` with `dp=1`.
- LZB all-zero: digits=16'h0000 with the macro defined.
  - Only digit 0 is enabled, showing `3F`.
  - Without the macro: all four digits show `3F`.
- Reset mid-operation and polarity: set SEG_ACTIVE_LOW=1 and SEL_ACTIVE_LOW=1, assert reset during digit 2.
  - `seg=7F`, `dp=1` and `digit_sel=1111` immediately.
  - After release, the scan restarts at digit 0 with a new `frame_tick`.
